// File: rtl/pipe_pkg.sv
// Shared forwarding encodings and the in-flight slot record.
package pipe_pkg;

    // fwd_sel encoding: 0 selects the register file, SEL_SLOT+k selects slot k
    localparam int unsigned SEL_RF     = 0;
    localparam int unsigned SEL_SLOT   = 1;

    // Slot field widths are fixed here; AW must not exceed SLOT_DST_W and
    // $clog2(DEPTH) must not exceed SLOT_CNT_W
    localparam int unsigned SLOT_DST_W = 8;
    localparam int unsigned SLOT_CNT_W = 4;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [SLOT_DST_W-1:0] dst;
        logic [SLOT_CNT_W-1:0] cnt;
    } slot_t;

    // Slot as it looks one stage further down: countdown saturates at zero
    function automatic slot_t slot_advance(input slot_t s);
        slot_t r;
        r = s;
        if (s.cnt != '0) begin
            r.cnt = s.cnt - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source hazard match, youngest-first priority and operand mux.
module fwd_select #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH+1)
) (
    input  logic [DEPTH-1:0]                     slot_valid,
    input  logic [DEPTH-1:0]                     slot_we,
    input  logic [DEPTH-1:0]                     slot_ready,
    input  logic [DEPTH*pipe_pkg::SLOT_DST_W-1:0] slot_dst,
    input  logic [AW-1:0]                        src_addr,
    input  logic [DW-1:0]                        src_rdata,
    input  logic [DEPTH*DW-1:0]                  stage_data,
    output logic [DW-1:0]                        operand,
    output logic [SW-1:0]                        fwd_sel,
    output logic                                 hazard
);
    import pipe_pkg::*;

    logic                  hit;
    logic [SLOT_DST_W-1:0] src_ext;

    assign src_ext = SLOT_DST_W'(src_addr);

    // First matching slot from slot 0 upward wins; register 0 never matches
    always_comb begin
        hit     = 1'b0;
        hazard  = 1'b0;
        fwd_sel = SW'(SEL_RF);
        operand = src_rdata;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit && slot_valid[k] && slot_we[k] && src_ext != '0 &&
                slot_dst[k*SLOT_DST_W +: SLOT_DST_W] == src_ext) begin
                hit = 1'b1;
                if (slot_ready[k]) begin
                    fwd_sel = SW'(SEL_SLOT + k);
                    operand = stage_data[k*DW +: DW];
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight destination tracker with operand forwarding and load-use stall.
module fwd_scoreboard #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              issue_valid,
    input  logic                              issue_we,
    input  logic [AW-1:0]                     issue_dst,
    input  logic [$clog2(DEPTH)-1:0]          issue_lat,
    input  logic [NSRC*AW-1:0]                src_addr,
    input  logic [NSRC*DW-1:0]                src_rdata,
    input  logic [DEPTH*DW-1:0]               stage_data,
    input  logic                              flush,
    output logic [NSRC*DW-1:0]                operand,
    output logic [NSRC*$clog2(DEPTH+1)-1:0]   fwd_sel,
    output logic                              stall,
    output logic [31:0]                       stall_cnt
);
    import pipe_pkg::*;

    localparam int SW = $clog2(DEPTH+1);

    slot_t                         slots [DEPTH];
    logic [DEPTH-1:0]              slot_valid;
    logic [DEPTH-1:0]              slot_we;
    logic [DEPTH-1:0]              slot_ready;
    logic [DEPTH*SLOT_DST_W-1:0]   slot_dst;
    logic [NSRC-1:0]               hazard;
    logic                          accept;

    // Flatten slot records into the vectors consumed by each selector
    always_comb begin
        slot_valid = '0;
        slot_we    = '0;
        slot_ready = '0;
        slot_dst   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot_valid[k]                        = slots[k].valid;
            slot_we[k]                           = slots[k].we;
            slot_ready[k]                        = (slots[k].cnt == '0);
            slot_dst[k*SLOT_DST_W +: SLOT_DST_W] = slots[k].dst;
        end
    end

    for (genvar n = 0; n < NSRC; n++) begin : g_src
        fwd_select #(
            .DW    (DW),
            .AW    (AW),
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_sel (
            .slot_valid (slot_valid),
            .slot_we    (slot_we),
            .slot_ready (slot_ready),
            .slot_dst   (slot_dst),
            .src_addr   (src_addr[n*AW +: AW]),
            .src_rdata  (src_rdata[n*DW +: DW]),
            .stage_data (stage_data),
            .operand    (operand[n*DW +: DW]),
            .fwd_sel    (fwd_sel[n*SW +: SW]),
            .hazard     (hazard[n])
        );
    end

    assign stall  = issue_valid & (|hazard) & ~reset;
    assign accept = issue_valid & ~stall & ~flush;

    // Slot pipeline: insert at slot 0 (or a bubble), shift down, retire the last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else begin
            if (accept) begin
                slots[0] <= '{valid: 1'b1, we: issue_we,
                              dst: SLOT_DST_W'(issue_dst),
                              cnt: SLOT_CNT_W'(issue_lat)};
            end else begin
                slots[0] <= '0;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                slots[k] <= slot_advance(slots[k-1]);
            end
        end
    end

    // Saturating count of refused issue cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DW, default 32: operand and stage data width.
REQ-002 Parameter AW, default 5: register address width.
REQ-003 Parameter NSRC, default 2: number of source operands per issuing instruction.
REQ-004 Parameter DEPTH, default 3: tracked in-flight stages (slot 0=EX, 1=MEM, 2=WB).
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port issue_valid, input, 1: an instruction presents sources and destination this cycle.
REQ-008 Port issue_we, input, 1: the issuing instruction writes a register.
REQ-009 Port issue_dst, input, AW: destination register of the issuing instruction.
REQ-010 Port issue_lat, input, $clog2(DEPTH): cycles after entering slot 0 until its result is valid; 0 for ALU, 1 for load.
REQ-011 Port src_addr, input, NSRC*AW: source register addresses, operand n at bits [n*AW +: AW].
REQ-012 Port src_rdata, input, NSRC*DW: register-file read data per source.
REQ-013 Port stage_data, input, DEPTH*DW: result currently produced by the instruction in slot k.
REQ-014 Port flush, input, 1: synchronous discard of all tracked entries.
REQ-015 Port operand, output, NSRC*DW: selected operand per source.
REQ-016 Port fwd_sel, output, NSRC*$clog2(DEPTH+1): 0=register file, k+1=slot k.
REQ-017 Port stall, output, 1: issue is refused this cycle.
REQ-018 Port stall_cnt, output, 32: count of stalled cycles.

Function
REQ-019 Each slot SHALL hold valid, we, dst, and a countdown cnt.
REQ-020 Accept SHALL equal issue_valid AND NOT stall; on accept slot 0 loads {1, issue_we, issue_dst, issue_lat}, otherwise a bubble (valid=0).
REQ-021 Every cycle slot k SHALL move to slot k+1 regardless of stall; slot DEPTH-1 retires.
REQ-022 cnt SHALL decrement by 1 on each move, saturating at 0.
REQ-023 A slot matches source n when valid, we, dst==src_addr[n], and dst!=0.
REQ-024 Among matches the lowest-numbered (youngest) slot SHALL win.
REQ-025 If the winning slot has cnt==0, fwd_sel[n]=slot+1 and operand[n]=stage_data[slot].
REQ-026 If the winning slot has cnt>0, stall SHALL be asserted when issue_valid=1.
REQ-027 If no slot matches, or src_addr[n]==0, fwd_sel[n]=0 and operand[n]=src_rdata[n].
REQ-028 stall, fwd_sel and operand SHALL be combinational in the current slot state and inputs, with zero latency.
REQ-029 stall SHALL be 0 whenever issue_valid=0.
REQ-030 stall_cnt SHALL increment on each cycle with stall=1 and saturate at 0xFFFFFFFF.
REQ-031 With flush=1, all slots SHALL become invalid at the next edge and no issue is accepted that cycle; stall_cnt is unaffected.

Reset
REQ-032 Reset SHALL asynchronously clear all slot valid bits, cnt values and stall_cnt to 0.
REQ-033 While reset is high, outputs SHALL be fwd_sel=0, operand=src_rdata and stall=0.
REQ-034 Reset asserted mid-operation SHALL discard pending entries immediately, without waiting for a clock edge.

Structure
REQ-035 The fwd_sel encoding constants (SEL_RF=0, SEL_SLOT base=1) and the slot record typedef SHALL live in shared package pipe_pkg.
REQ-036 Per-source match, priority and mux logic SHALL be one sub-module, fwd_select, instantiated NSRC times; slot storage stays in the top module.

Verification (DEPTH=3, NSRC=2)
REQ-037 Issue $3 lat0, then src0=$3 with stage_data[0]=0x00000011 -> stall=0, fwd_sel0=1, operand0=0x11.
REQ-038 Issue load $5 lat1, then src1=$5 -> one cycle stall=1 with stall_cnt 0->1; next cycle fwd_sel1=2 and operand1=stage_data[1].
REQ-039 $7 pending in slot0 (cnt0) and slot1 (cnt0), src0=$7 -> fwd_sel0=1 (youngest wins).
REQ-040 Producer writes $0, then src0=$0 with src_rdata0=0xDEADBEEF -> fwd_sel0=0, operand0=0xDEADBEEF, stall=0.
REQ-041 Load $5 pending with consumer stalled, flush=1 -> the next cycle stall=0, fwd_sel=0.
REQ-042 Reset pulsed between clock edges with entries pending -> slots clear at once, stall=0 and stall_cnt=0 before the next edge.
